// File: rtl/feature_frame_scheduler.sv
// ---------------------------------------------------------------------------
// feature_frame_scheduler
//
// Sits between the per-frame channel barrier and the serial feature
// extractor. A frame_ready pulse snapshots every channel energy and the
// channel enable mask. The enabled channels are then streamed one beat per
// channel, in ascending index order, over a valid/ready interface. The block
// then waits for the extractor's completion pulse and emits a one-cycle
// frame_done. frame_ready pulses that arrive while a frame is in flight are
// discarded and counted.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_ready   one-cycle pulse: chan_energy / chan_enable are valid
//   chan_energy   packed energies, channel i at [i*DATA_W +: DATA_W]
//   chan_enable   channel enable mask, latched when a frame is accepted
//   out_valid     beat valid towards the extractor
//   out_ready     extractor accepts the current beat
//   out_data      snapshotted energy of the current channel
//   out_chan      index of the current channel (zero-extended)
//   out_last      current beat is the highest enabled channel
//   fe_done       extractor finished the frame (pulse)
//   frame_done    one-cycle end-of-frame pulse
//   busy          high whenever a frame is in progress
//   overrun_cnt   saturating count of rejected frame_ready pulses
//   timeout_err   sticky: fe_done did not arrive within TIMEOUT cycles
//   err_clr       clears overrun_cnt and timeout_err
// ---------------------------------------------------------------------------
module feature_frame_scheduler #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_ready,
    input  logic [NUM_CHANNELS*DATA_W-1:0]   chan_energy,
    input  logic [NUM_CHANNELS-1:0]          chan_enable,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [3:0]                       out_chan,
    output logic                             out_last,
    input  logic                             fe_done,
    output logic                             frame_done,
    output logic                             busy,
    output logic [CNT_W-1:0]                 overrun_cnt,
    output logic                             timeout_err,
    input  logic                             err_clr
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_FE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]              r_state;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_W-1:0]       r_shadow [NUM_CHANNELS];
    logic [TO_W-1:0]         r_to_cnt;
    logic [CNT_W-1:0]        r_ovr;
    logic                    r_to_err;

    logic                    w_issue;
    logic [IDX_W-1:0]        w_first_idx;
    logic                    w_first_any;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_next_any;
    logic [TO_W-1:0]         w_to_inc;
    logic                    w_to_expire;

    assign w_issue = (r_state == S_ISSUE);

    // Two priority encoders: lowest enabled channel of the incoming mask, and
    // lowest latched channel strictly above the current index (equivalent to
    // mask & ~((2<<idx)-1)). Both are purely combinational so consecutive
    // enabled channels issue back-to-back regardless of gaps in the mask.
    always_comb begin
        w_first_idx = '0;
        w_first_any = 1'b0;
        w_next_idx  = '0;
        w_next_any  = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_first_any && chan_enable[i]) begin
                w_first_any = 1'b1;
                w_first_idx = IDX_W'(i);
            end
            if (!w_next_any && r_mask[i] && (IDX_W'(i) > r_idx)) begin
                w_next_any = 1'b1;
                w_next_idx = IDX_W'(i);
            end
        end
    end

    // The counter starts at 0 in the first WAIT_FE cycle; timing out when the
    // incremented value reaches TIMEOUT-1 puts frame_done exactly TIMEOUT
    // cycles after the last handshake.
    assign w_to_inc    = r_to_cnt + 1'b1;
    assign w_to_expire = (w_to_inc >= TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_idx    <= '0;
            r_to_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_ready) begin
                        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                            r_shadow[i] <= chan_energy[i*DATA_W +: DATA_W];
                        end
                        r_mask  <= chan_enable;
                        r_idx   <= w_first_idx;
                        r_state <= w_first_any ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        if (w_next_any) begin
                            r_idx <= w_next_idx;
                        end else begin
                            r_state  <= S_WAIT_FE;
                            r_to_cnt <= '0;
                        end
                    end
                end
                S_WAIT_FE: begin
                    if (fe_done || w_to_expire) begin
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Error bookkeeping: err_clr takes priority over a coincident set/increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr    <= '0;
            r_to_err <= 1'b0;
        end else begin
            if (err_clr) begin
                r_ovr <= '0;
            end else if (frame_ready && (r_state != S_IDLE) && (r_ovr != '1)) begin
                r_ovr <= r_ovr + 1'b1;
            end

            if (err_clr) begin
                r_to_err <= 1'b0;
            end else if ((r_state == S_WAIT_FE) && !fe_done && w_to_expire) begin
                r_to_err <= 1'b1;
            end
        end
    end

    assign out_valid   = w_issue;
    assign out_data    = w_issue ? r_shadow[r_idx] : '0;
    assign out_chan    = w_issue ? 4'(r_idx) : 4'd0;
    assign out_last    = w_issue && !w_next_any;
    assign frame_done  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign overrun_cnt = r_ovr;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_feature_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_feature_frame_scheduler
//
// Directed bench for feature_frame_scheduler (8 channels, 32-bit data,
// TIMEOUT=16, 8-bit overrun counter). Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, when they reflect the
// state registered on that edge.
// ---------------------------------------------------------------------------
module tb_feature_frame_scheduler;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst;
    logic            frame_ready;
    logic [N*DW-1:0] chan_energy;
    logic [N-1:0]    chan_enable;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_chan;
    logic            out_last;
    logic            fe_done;
    logic            frame_done;
    logic            busy;
    logic [7:0]      overrun_cnt;
    logic            timeout_err;
    logic            err_clr;

    int checks   = 0;
    int failures = 0;

    feature_frame_scheduler #(
        .NUM_CHANNELS (8),
        .DATA_W       (32),
        .TIMEOUT      (16),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_ready (frame_ready),
        .chan_energy (chan_energy),
        .chan_enable (chan_enable),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_last    (out_last),
        .fe_done     (fe_done),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [3:0] ch,
                              input logic [31:0] data, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".chan"},  32'(out_chan),  32'(ch));
        check({tag, ".data"},  out_data,       data);
        check({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 32'(out_valid),   32'd0);
        check({tag, ".data"},  out_data,         32'd0);
        check({tag, ".chan"},  32'(out_chan),    32'd0);
        check({tag, ".last"},  32'(out_last),    32'd0);
        check({tag, ".fdone"}, 32'(frame_done),  32'd0);
        check({tag, ".busy"},  32'(busy),        32'd0);
        check({tag, ".ovr"},   32'(overrun_cnt), 32'd0);
        check({tag, ".toerr"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        frame_ready = 1'b0;
        chan_energy = '0;
        chan_enable = '0;
        out_ready   = 1'b0;
        fe_done     = 1'b0;
        err_clr     = 1'b0;

        // Reset state
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // All-enabled frame: energies i*16+1
        for (int i = 0; i < 8; i++) chan_energy[i*32 +: 32] = 32'(i*16 + 1);
        chan_enable = 8'hFF;
        out_ready   = 1'b1;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_beat("all.beat", 4'(i), 32'(i*16 + 1), (i == 7));
            step();
        end
        // Now at H+1 after the last handshake
        check("all.valid_drop", 32'(out_valid), 32'd0);
        check("all.busy_wait", 32'(busy), 32'd1);
        step();
        check("all.fdone_h2", 32'(frame_done), 32'd0);
        step();
        check("all.fdone_h3", 32'(frame_done), 32'd0);
        fe_done = 1'b1;
        step();
        fe_done = 1'b0;
        check("all.fdone_h4", 32'(frame_done), 32'd1);
        step();
        check("all.fdone_h5", 32'(frame_done), 32'd0);
        check("all.busy_after", 32'(busy), 32'd0);

        // Sparse mask with backpressure: channels 2, 5, 7
        chan_enable = 8'b1010_0100;
        out_ready   = 1'b0;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check_beat("sparse.c2", 4'd2, 32'd33, 1'b0);
        step();
        check_beat("sparse.c2_hold", 4'd2, 32'd33, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_beat("sparse.c5", 4'd5, 32'd81, 1'b0);
        step();
        check_beat("sparse.c5_hold", 4'd5, 32'd81, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_beat("sparse.c7", 4'd7, 32'd113, 1'b1);
        step();
        check_beat("sparse.c7_hold", 4'd7, 32'd113, 1'b1);
        out_ready = 1'b1;
        step();
        check("sparse.valid_drop", 32'(out_valid), 32'd0);
        fe_done = 1'b1;
        step();
        fe_done = 1'b0;
        check("sparse.fdone", 32'(frame_done), 32'd1);
        step();
        check("sparse.busy_after", 32'(busy), 32'd0);

        // Zero mask: frame_done one cycle after frame_ready, no beats
        chan_enable = 8'h00;
        frame_ready = 1'b1;
        step();
        check("zero.valid", 32'(out_valid), 32'd0);
        check("zero.fdone", 32'(frame_done), 32'd1);
        // frame_ready held into DONE counts as an overrun
        step();
        frame_ready = 1'b0;
        check("zero.ovr_done", 32'(overrun_cnt), 32'd1);
        check("zero.busy", 32'(busy), 32'd0);
        check("zero.fdone_off", 32'(frame_done), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("zero.ovr_clr", 32'(overrun_cnt), 32'd0);

        // Overrun during ISSUE and snapshot isolation
        chan_enable = 8'h03;
        out_ready   = 1'b0;
        frame_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) chan_energy[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
        chan_enable = 8'hFF;
        step();
        frame_ready = 1'b0;
        check("ovr.cnt1", 32'(overrun_cnt), 32'd1);
        check_beat("ovr.c0", 4'd0, 32'd1, 1'b0);
        out_ready = 1'b1;
        step();
        check_beat("ovr.c1", 4'd1, 32'd17, 1'b1);
        step();
        check("ovr.valid_drop", 32'(out_valid), 32'd0);
        fe_done = 1'b1;
        step();
        fe_done = 1'b0;
        check("ovr.fdone", 32'(frame_done), 32'd1);
        step();
        check("ovr.fdone_once", 32'(frame_done), 32'd0);
        check("ovr.busy_after", 32'(busy), 32'd0);

        // New frame picks up the altered energies; second overrun, then
        // err_clr coinciding with a third overrun
        chan_enable = 8'h01;
        out_ready   = 1'b0;
        frame_ready = 1'b1;
        step();
        check_beat("ovr2.c0", 4'd0, 32'hDEAD_0000, 1'b1);
        step();
        check("ovr2.cnt2", 32'(overrun_cnt), 32'd2);
        err_clr = 1'b1;
        step();
        frame_ready = 1'b0;
        err_clr     = 1'b0;
        check("ovr2.clr_wins", 32'(overrun_cnt), 32'd0);

        // Timeout: handshake the only beat, never pulse fe_done
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (14) step();
        check("to.fdone_h15", 32'(frame_done), 32'd0);
        check("to.err_h15", 32'(timeout_err), 32'd0);
        check("to.busy_h15", 32'(busy), 32'd1);
        step();
        check("to.fdone_h16", 32'(frame_done), 32'd1);
        check("to.err_h16", 32'(timeout_err), 32'd1);
        step();
        check("to.busy_after", 32'(busy), 32'd0);
        check("to.err_sticky", 32'(timeout_err), 32'd1);

        chan_enable = 8'h80;
        out_ready   = 1'b1;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check_beat("to.next_c7", 4'd7, 32'hDEAD_0007, 1'b1);
        step();
        fe_done = 1'b1;
        step();
        fe_done = 1'b0;
        check("to.next_fdone", 32'(frame_done), 32'd1);
        check("to.err_still", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to.err_clr", 32'(timeout_err), 32'd0);
        check("to.busy_end", 32'(busy), 32'd0);

        // Overrun saturation, then reset during the third beat
        chan_enable = 8'b0011_1010;
        out_ready   = 1'b0;
        frame_ready = 1'b1;
        step();
        repeat (260) step();
        frame_ready = 1'b0;
        check("sat.cnt", 32'(overrun_cnt), 32'd255);
        check_beat("sat.c1_hold", 4'd1, 32'hDEAD_0001, 1'b0);
        out_ready = 1'b1;
        step();
        check_beat("rst.c3", 4'd3, 32'hDEAD_0003, 1'b0);
        step();
        check_beat("rst.c4", 4'd4, 32'hDEAD_0004, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("midrst");

        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check_beat("post.c1", 4'd1, 32'hDEAD_0001, 1'b0);
        step();
        check_beat("post.c3", 4'd3, 32'hDEAD_0003, 1'b0);
        step();
        check_beat("post.c4", 4'd4, 32'hDEAD_0004, 1'b0);
        step();
        check_beat("post.c5", 4'd5, 32'hDEAD_0005, 1'b1);
        step();
        check("post.valid_drop", 32'(out_valid), 32'd0);
        fe_done = 1'b1;
        step();
        fe_done = 1'b0;
        check("post.fdone", 32'(frame_done), 32'd1);
        step();
        check("post.busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/feature_frame_scheduler.md
Name: feature_frame_scheduler

Overview:
Sequencer between the per-frame channel barrier and the serial feature extractor. On each frame-ready pulse it snapshots all per-channel bandpower energies. It then feeds the enabled channels one at a time, in ascending index order, over a valid/ready stream. It waits for the extractor's completion pulse, signals end of frame, and counts frames that arrive while a frame is still in progress (overruns).

Parameters:
NUM_CHANNELS, 8, number of parallel channels; range 1..16
DATA_W, 32, width of one channel energy word
TIMEOUT, 1024, max cycles to wait for fe_done after the last beat; must be >= 1
CNT_W, 8, width of the saturating overrun counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_ready  in  1  one-cycle pulse: all channel energies valid
chan_energy  in  NUM_CHANNELS*DATA_W  packed energies; channel i at bits [i*DATA_W +: DATA_W]
chan_enable  in  NUM_CHANNELS  channel enable mask, sampled on frame accept
out_valid  out  1  beat valid to extractor
out_ready  in  1  extractor accepts beat
out_data  out  DATA_W  snapshotted energy of current channel
out_chan  out  4  index of current channel
out_last  out  1  current beat is the last enabled channel
fe_done  in  1  extractor finished frame (pulse)
frame_done  out  1  one-cycle end-of-frame pulse
busy  out  1  high in any state other than IDLE
overrun_cnt  out  CNT_W  saturating count of rejected frame_ready pulses
timeout_err  out  1  sticky: fe_done not seen within TIMEOUT
err_clr  in  1  clears overrun_cnt and timeout_err

Behaviour:
- Reset: state=IDLE; every output 0; shadow registers and latched mask 0.
- Reset asserted mid-frame: abort immediately to IDLE. No frame_done. A beat in flight is dropped.
- States are IDLE, ISSUE, WAIT_FE, DONE.
- IDLE, frame_ready=1:
  - Copy chan_energy into the shadow registers and latch chan_enable into the mask.
  - Mask nonzero: idx = lowest set bit; go to ISSUE.
  - Mask zero: go to DONE.
  - Latency: frame_ready at cycle T gives out_valid=1 at T+1, or frame_done=1 at T+1 when the mask is zero.
- ISSUE:
  - out_valid=1; out_data=shadow[idx]; out_chan=idx.
  - out_last=1 when no mask bit above idx is set.
  - out_data, out_chan and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready with out_last=0: idx = next set bit above idx; stay in ISSUE. Back-to-back beats allowed, one per cycle.
  - On out_valid and out_ready with out_last=1: go to WAIT_FE, clear the timeout counter, drop out_valid the next cycle.
- WAIT_FE:
  - fe_done=1: go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without fe_done, set timeout_err and go to DONE.
  - fe_done in any other state is ignored.
- DONE: frame_done=1 for exactly one cycle, then return to IDLE.
- Overrun:
  - frame_ready while state != IDLE (this includes DONE) increments overrun_cnt, saturating at 2^CNT_W-1.
  - That frame is discarded; shadow registers are unchanged.
- err_clr:
  - Clears overrun_cnt and timeout_err the next cycle.
  - When err_clr coincides with an increment or a timeout set, the clear wins.
- Shadow isolation: chan_energy may change freely after accept; beats always carry the snapshot values.
- Next-set-bit search is a combinational priority encoder over mask & ~((2<<idx)-1). There are no idle cycles between enabled channels, even when the mask is sparse.
- out_chan is zero-extended from clog2(NUM_CHANNELS) bits.

Test Plan:
- All-enabled frame:
  - Stimulus: mask=8'hFF, energies i*16+1, out_ready=1, fe_done 3 cycles after the last beat.
  - Required: 8 consecutive beats, chan 0..7, data 1,17,...,113, out_last only on chan 7; frame_done 4 cycles after the last handshake; busy low afterwards.
- Sparse mask plus backpressure:
  - Stimulus: mask=8'b1010_0100, out_ready toggling 1/0.
  - Required: beats chan 2,5,7 only; data held stable while stalled; out_last on chan 7.
- Zero mask:
  - Stimulus: frame_ready with chan_enable=0.
  - Required: no out_valid; frame_done one cycle after frame_ready.
- Overrun and snapshot isolation:
  - Stimulus: second frame_ready during ISSUE; chan_energy altered mid-frame.
  - Required: overrun_cnt=1; beat data equals the first snapshot; only one frame_done. Then err_clr together with a third overrun gives overrun_cnt=0.
- Timeout:
  - Stimulus: TIMEOUT=16, fe_done never asserted.
  - Required: timeout_err=1 and frame_done 16 cycles after the last handshake; next frame accepted normally; err_clr clears timeout_err.
- Mid-frame reset:
  - Stimulus: rst during the 3rd beat.
  - Required: next cycle all outputs 0 and busy=0; a following frame starts again at the lowest enabled channel.
